dma_fifo_unpack_ctrl: RTL and testbench

- Sequencing stage wrapped around the DMA 32-to-8 unpacking FIFO.
- Accepts one 32-bit word from the processor side with a valid/ready handshake and pulses the FIFO `write` strobe.
- Then steps the FIFO `read[1:0]` select through the required byte lanes.
- Presents each byte that the FIFO returns on `data_out_8bit` to the 8-bit DMA byte bus with a valid/ready handshake.
- Supports partial words (1-4 bytes), either byte order, and a synchronous abort.

---
 rtl/dma_fifo_unpack_ctrl.sv | 98 +++++++++
 tb/tb_dma_fifo_unpack_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_unpack_ctrl.sv
// Sequencing stage for the DMA 32-to-8 unpacking FIFO: accepts a word, writes it to the FIFO,
// then steps the FIFO lane select and presents each returned byte with a valid/ready handshake.
module dma_fifo_unpack_ctrl #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  input  logic [1:0]  byte_count,
  output logic        fifo_write,
  output logic [31:0] fifo_wdata,
  output logic [1:0]  fifo_read,
  input  logic [7:0]  fifo_rdata,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        last_byte,
  output logic        busy,
  input  logic        abort
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StPresent = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  remain_q, remain_d;

  localparam logic [1:0] FirstLane = BIG_ENDIAN ? 2'd3 : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      lane_q   <= 2'd0;
      remain_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      remain_q <= remain_d;
    end
  end

  // Outputs are gated by reset so they read low in the very cycle reset is raised.
  always_comb begin
    word_ready = (state_q == StIdle) && !reset && !abort;
    fifo_write = word_valid && word_ready;
    fifo_wdata = word_data;
    fifo_read  = lane_q;
    byte_out   = fifo_rdata;
    byte_valid = (state_q == StPresent) && !reset;
    busy       = (state_q != StIdle) && !reset;
    last_byte  = byte_valid && (remain_q == 3'd1);
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    remain_d = remain_q;
    if (abort) begin
      state_d  = StIdle;
      remain_d = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fifo_write) begin
            remain_d = (byte_count == 2'd0) ? 3'd4 : {1'b0, byte_count};
            lane_d   = FirstLane;
            state_d  = StFetch;
          end
        end
        StFetch: begin
          state_d = StPresent;
        end
        StPresent: begin
          if (byte_ready) begin
            if (remain_q == 3'd1) begin
              state_d = StIdle;
            end else begin
              // The FIFO samples the old lane at this edge, so moving lane here is glitch-free.
              remain_d = remain_q - 3'd1;
              lane_d   = BIG_ENDIAN ? (lane_q - 2'd1) : (lane_q + 2'd1);
              state_d  = StFetch;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_fifo_unpack_ctrl.sv
// Scoreboard bench: one little-endian and one big-endian instance share stimulus; each has its
// own FIFO model, and a reference model predicts accepts, byte order, lanes and timing.
module tb_dma_fifo_unpack_ctrl;

  logic        clk = 1'b0;
  logic        reset, word_valid, byte_ready, abort;
  logic [31:0] word_data;
  logic [1:0]  byte_count;

  logic        word_ready0, fifo_write0, byte_valid0, last_byte0, busy0;
  logic [31:0] fifo_wdata0;
  logic [1:0]  fifo_read0;
  logic [7:0]  fifo_rdata0, byte_out0;
  logic        word_ready1, fifo_write1, byte_valid1, last_byte1, busy1;
  logic [31:0] fifo_wdata1;
  logic [1:0]  fifo_read1;
  logic [7:0]  fifo_rdata1, byte_out1;

  always #5 clk = ~clk;

  dma_fifo_unpack_ctrl #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_ready(word_ready0),
    .word_data(word_data), .byte_count(byte_count), .fifo_write(fifo_write0),
    .fifo_wdata(fifo_wdata0), .fifo_read(fifo_read0), .fifo_rdata(fifo_rdata0),
    .byte_out(byte_out0), .byte_valid(byte_valid0), .byte_ready(byte_ready),
    .last_byte(last_byte0), .busy(busy0), .abort(abort)
  );

  dma_fifo_unpack_ctrl #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_ready(word_ready1),
    .word_data(word_data), .byte_count(byte_count), .fifo_write(fifo_write1),
    .fifo_wdata(fifo_wdata1), .fifo_read(fifo_read1), .fifo_rdata(fifo_rdata1),
    .byte_out(byte_out1), .byte_valid(byte_valid1), .byte_ready(byte_ready),
    .last_byte(last_byte1), .busy(busy1), .abort(abort)
  );

  // FIFO models: word captured on write, byte registered from the selected lane.
  logic [31:0] mem0 = '0, mem1 = '0;
  always @(posedge clk) begin
    if (fifo_write0) mem0 <= fifo_wdata0;
    if (fifo_write1) mem1 <= fifo_wdata1;
    fifo_rdata0 <= mem0[8*fifo_read0 +: 8];
    fifo_rdata1 <= mem1[8*fifo_read1 +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [1:0] lane;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ready_at = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model + monitor, sampled on the falling edge.
  bit   empty, exp_wr, exp_bv;
  int   n;
  logic [1:0] ln;
  always @(negedge clk) begin
    empty  = (q0.size() == 0);
    exp_wr = !reset && !abort && empty;
    exp_bv = !reset && !empty && (cyc >= ready_at);

    check("word_ready_le", word_ready0, exp_wr);
    check("word_ready_be", word_ready1, exp_wr);
    check("fifo_write_le", fifo_write0, exp_wr && word_valid);
    check("fifo_write_be", fifo_write1, exp_wr && word_valid);
    check("busy_le", busy0, !reset && !empty);
    check("busy_be", busy1, !reset && !empty);
    check("byte_valid_le", byte_valid0, exp_bv);
    check("byte_valid_be", byte_valid1, exp_bv);
    if (!reset && !empty) begin
      check("fifo_read_le", fifo_read0, q0[0].lane);
      check("fifo_read_be", fifo_read1, q1[0].lane);
    end
    if (exp_bv) begin
      check("byte_out_le", byte_out0, q0[0].b);
      check("byte_out_be", byte_out1, q1[0].b);
      check("last_byte_le", last_byte0, q0[0].last);
      check("last_byte_be", last_byte1, q1[0].last);
    end else begin
      check("last_byte_idle_le", last_byte0, 0);
      check("last_byte_idle_be", last_byte1, 0);
    end

    if (reset || abort) begin
      q0.delete();
      q1.delete();
    end else if (exp_bv && byte_ready) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      ready_at = cyc + 2;
    end else if (exp_wr && word_valid) begin
      n = (byte_count == 2'd0) ? 4 : int'(byte_count);
      for (int i = 0; i < n; i++) begin
        ln = 2'(i);
        q0.push_back('{b: word_data[8*ln +: 8], last: (i == n - 1), lane: ln});
        ln = 2'(3 - i);
        q1.push_back('{b: word_data[8*ln +: 8], last: (i == n - 1), lane: ln});
      end
      ready_at = cyc + 2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] c);
    word_valid = 1'b1;
    word_data  = d;
    byte_count = c;
    tick();
    word_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; word_valid = 1'b0; word_data = '0; byte_count = '0;
    byte_ready = 1'b0; abort = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_fifo_read_le", fifo_read0, 0);
    check("post_reset_fifo_read_be", fifo_read1, 0);
    tick();

    // Full word, always ready.
    byte_ready = 1'b1;
    send(32'h44332211, 2'd0);
    repeat (10) tick();
    // Two-byte word.
    send(32'hA1B2C3D4, 2'd2);
    repeat (6) tick();
    // Backpressure on the second byte.
    send(32'h44332211, 2'd0);
    repeat (2) tick();
    byte_ready = 1'b0;
    repeat (6) tick();
    byte_ready = 1'b1;
    repeat (8) tick();
    // word_valid held across two words.
    word_valid = 1'b1; word_data = 32'h8877_6655; byte_count = 2'd3;
    repeat (12) tick();
    word_valid = 1'b0;
    repeat (4) tick();
    // Abort while presenting byte 2, then a single-byte word.
    send(32'h44332211, 2'd0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    send(32'h000000EE, 2'd1);
    repeat (5) tick();
    // Reset during FETCH.
    send(32'h12345678, 2'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_fetch_fifo_read_le", fifo_read0, 0);
    check("reset_fetch_fifo_read_be", fifo_read1, 0);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      word_valid = ($urandom_range(0, 9) < 7);
      word_data  = $urandom;
      byte_count = 2'($urandom_range(0, 3));
      byte_ready = ($urandom_range(0, 9) < 6);
      abort      = ($urandom_range(0, 99) < 3);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; abort = 1'b0; word_valid = 1'b0; byte_ready = 1'b1;
    repeat (12) tick();
    check("drained", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
